gate_truth_sequencer: RTL and testbench

- Controller that exhaustively exercises a small combinational gate-under-test (e.g. an AND built from NOR gates) by stepping through every input combination in binary order.
- Holds each combination for a programmable settle time, then samples the gate output into a truth-table register.
- Compares the captured table against an expected table and reports pass/fail.
- Sits between a combinational gate block and a board-level status/LED interface; it replaces hand-written stimulus with on-chip sequencing.

---
 rtl/gate_seq_pkg.sv | 20 ++
 rtl/settle_timer.sv | 31 +++
 rtl/gate_truth_sequencer.sv | 105 ++++++++++
 tb/tb_gate_truth_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared state encoding and helpers for the gate truth sequencer
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam int N_IN_MAX = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - dwell counter that ticks on the last cycle of each hold period
module settle_timer
    import gate_seq_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = clog2(DWELL) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] dwell_cnt;

    assign tick = en && (dwell_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
        end else if (clr || tick) begin
            dwell_cnt <= '0;
        end else if (en) begin
            dwell_cnt <= dwell_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/gate_truth_sequencer.sv
// rtl/gate_truth_sequencer.sv - sweeps every gate input vector, captures and grades the truth table
module gate_truth_sequencer
    import gate_seq_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DWELL = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   truth,
    output logic [(1<<N_IN)-1:0]   fail_mask,
    output logic                   pass
);

    localparam int W = 1 << N_IN;
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(W - 1);

    seq_state_t      state;
    logic [N_IN-1:0] idx;
    logic [W-1:0]    expected_latched;
    logic [W-1:0]    truth_next;
    logic            in_apply;
    logic            tick;

    assign in_apply = (state == ST_APPLY);

    settle_timer #(.DWELL(DWELL)) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_apply || abort),
        .en    (in_apply),
        .tick  (tick)
    );

    // Grading uses the table including the bit captured on the final edge.
    always_comb begin
        truth_next      = truth;
        truth_next[idx] = dut_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            idx              <= '0;
            expected_latched <= '0;
            dut_in           <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            truth            <= '0;
            fail_mask        <= '0;
            pass             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        expected_latched <= expected;
                        truth            <= '0;
                        idx              <= '0;
                        dut_in           <= '0;
                        busy             <= 1'b1;
                        state            <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        idx    <= '0;
                        dut_in <= '0;
                        busy   <= 1'b0;
                        truth  <= '0;
                    end else if (tick) begin
                        truth <= truth_next;
                        if (idx == IDX_LAST) begin
                            state     <= ST_DONE;
                            idx       <= '0;
                            dut_in    <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail_mask <= truth_next ^ expected_latched;
                            pass      <= (truth_next == expected_latched);
                        end else begin
                            idx    <= idx + 1'b1;
                            dut_in <= idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// tb/tb_gate_truth_sequencer.sv - randomized self-checking bench for gate_truth_sequencer
module tb_gate_truth_sequencer;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int D  = 2;

    logic         clk;
    logic         rst_n;
    logic         start, abort, start1;
    logic [W-1:0] expected;
    logic [N-1:0] dut_in, dut_in1;
    logic         dut_out, dut_out1;
    logic         busy, done, pass, busy1, done1, pass1;
    logic [W-1:0] truth, fail_mask, truth1, fail_mask1;

    int           gate_sel;
    logic [W-1:0] rand_tt;
    int           errors;
    int           checks;
    logic         prev_pass;
    logic [W-1:0] prev_fail;

    gate_truth_sequencer #(.N_IN(N), .DWELL(D)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
        .truth(truth), .fail_mask(fail_mask), .pass(pass)
    );

    gate_truth_sequencer #(.N_IN(N), .DWELL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .expected(4'b1000),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
        .truth(truth1), .fail_mask(fail_mask1), .pass(pass1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gates under test: AND built from NOR, stuck-at-0, OR, random lookup.
    logic na, nb, na1, nb1;
    always_comb begin
        na = ~(dut_in[0] | dut_in[0]);
        nb = ~(dut_in[1] | dut_in[1]);
        case (gate_sel)
            0:       dut_out = ~(na | nb);
            1:       dut_out = 1'b0;
            2:       dut_out = dut_in[0] | dut_in[1];
            default: dut_out = rand_tt[dut_in];
        endcase
        na1      = ~(dut_in1[0] | dut_in1[0]);
        nb1      = ~(dut_in1[1] | dut_in1[1]);
        dut_out1 = ~(na1 | nb1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_tt(input int g);
        logic [W-1:0] t;
        for (int i = 0; i < W; i++) begin
            case (g)
                0:       t[i] = (i == 3);
                1:       t[i] = 1'b0;
                2:       t[i] = (i != 0);
                default: t[i] = rand_tt[i];
            endcase
        end
        return t;
    endfunction

    task automatic run_sweep(input int g, input logic [W-1:0] exp_tt,
                             input int restart_j, input int abort_j);
        logic [W-1:0] tt;
        logic [W-1:0] fm;
        gate_sel = g;
        tt       = model_tt(g);
        fm       = tt ^ exp_tt;
        expected = exp_tt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("truth_cleared", 32'(truth), 32'd0);
        for (int j = 0; j < W * D; j++) begin
            if (j == 1) expected = W'($urandom);
            check("busy_sweep", 32'(busy), 32'd1);
            check("dut_in_step", 32'(dut_in), 32'(j / D));
            check("no_early_done", 32'(done), 32'd0);
            if (j == abort_j) begin
                abort = 1'b1;
                @(negedge clk) abort = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_dut_in", 32'(dut_in), 32'd0);
                check("abort_truth", 32'(truth), 32'd0);
                check("abort_pass_kept", 32'(pass), 32'(prev_pass));
                check("abort_fail_kept", 32'(fail_mask), 32'(prev_fail));
                for (int k = 0; k < W * D; k++) begin
                    check("abort_no_done", 32'(done | busy), 32'd0);
                    @(negedge clk);
                end
                return;
            end
            start = (j == restart_j);
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("truth", 32'(truth), 32'(tt));
        check("fail_mask", 32'(fail_mask), 32'(fm));
        check("pass", 32'(pass), 32'(fm == '0));
        prev_pass = (fm == '0);
        prev_fail = fm;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_no_done", 32'(done | busy), 32'd0);
            check("truth_held", 32'(truth), 32'(tt));
            check("pass_held", 32'(pass), 32'(prev_pass));
        end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
        expected = '0; gate_sel = 0; rand_tt = '0;
        prev_pass = 1'b0; prev_fail = '0;
        repeat (2) @(negedge clk);
        check("rst_dut_in", 32'(dut_in), 32'd0);
        check("rst_busy_done", 32'({busy, done, pass}), 32'd0);
        check("rst_truth", 32'(truth), 32'd0);
        check("rst_fail_mask", 32'(fail_mask), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 4'b1000, -1, -1);
        run_sweep(1, 4'b1000, -1, -1);
        run_sweep(0, 4'b1000, 2, -1);
        run_sweep(2, 4'b1000, -1, -1);
        run_sweep(0, 4'b1000, -1, 3);
        run_sweep(0, 4'b1000, -1, -1);

        // Start and abort together in IDLE: abort wins.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        check("start_abort_idle", 32'(busy), 32'd0);
        @(negedge clk);
        check("start_abort_idle2", 32'(busy), 32'd0);

        for (int r = 0; r < 8; r++) begin
            int g;
            g       = $urandom_range(0, 3);
            rand_tt = W'($urandom);
            if ($urandom_range(0, 1) == 0)
                run_sweep(g, model_tt(g), -1, -1);
            else
                run_sweep(g, W'($urandom), -1, -1);
        end

        // Asynchronous reset in the middle of a sweep.
        gate_sel = 0;
        expected = 4'b1000;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'({busy, done, pass, dut_in}), 32'd0);
        check("async_rst_tables", 32'({truth, fail_mask}), 32'd0);
        check("async_rst_dut1", 32'({busy1, done1, pass1, dut_in1, truth1}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // DWELL=1 instance: one vector per cycle.
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int j = 0; j < W; j++) begin
            check("d1_busy", 32'(busy1), 32'd1);
            check("d1_dut_in", 32'(dut_in1), 32'(j));
            check("d1_no_early_done", 32'(done1), 32'd0);
            @(negedge clk);
        end
        check("d1_done", 32'(done1), 32'd1);
        check("d1_truth", 32'(truth1), 32'h8);
        check("d1_pass", 32'({pass1, fail_mask1}), 32'h10);
        @(negedge clk);
        check("d1_done_cleared", 32'(done1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
